// File: rtl/axi_ad9152_dac_fifo_if.sv
// DMA-to-DAC-FIFO sample stream: 128-bit words with valid/ready handshake.
// master = DMA (drives valid/data), slave = FIFO (drives ready).
interface axi_ad9152_dac_fifo_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/axi_ad9152_dac_fifo.sv
// AD9152 DAC sample FIFO: buffers 128-bit DMA words, prefills, unpacks per channel.
// Ports: dac_clk/dac_rstn, s_axis (slave stream), dac_valid/enable in, dac_ddata/dunf out.
module axi_ad9152_dac_fifo #(
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int START_LEVEL     = 4
) (
    input  logic                  dac_clk,
    input  logic                  dac_rstn,
    axi_ad9152_dac_fifo_if.slave  s_axis,
    input  logic                  dac_valid_0,
    input  logic                  dac_valid_1,
    input  logic                  dac_enable_0,
    input  logic                  dac_enable_1,
    output logic [63:0]           dac_ddata_0,
    output logic [63:0]           dac_ddata_1,
    output logic                  dac_dunf
);
    localparam int AW = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_L = (AW+1)'(START_LEVEL);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    level, level_d;
    logic           phase_q, phase_d;
    logic           ready_d;
    logic [63:0]    dd0_d, dd1_d, half;
    logic           dunf_d;
    logic           consume, push, flush, clr;
    logic           empty, pop_req;
    logic [1:0]     en;
    logic [127:0]   mem [DEPTH];
    logic [127:0]   rd_word;

    assign en      = {dac_enable_1, dac_enable_0};
    assign pop_req = dac_valid_0 | dac_valid_1;
    assign empty   = (level == '0);
    assign rd_word = mem[rd_ptr];

    // Any enable change while active drops back to IDLE and flushes.
    assign flush = (state_q != IDLE) && (en != mode_q);
    assign clr   = (state_q == IDLE) || flush;
    assign push  = s_axis.valid && s_axis.ready && !flush;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        consume = 1'b0;
        dd0_d   = '0;
        dd1_d   = '0;
        dunf_d  = 1'b0;
        half    = '0;
        unique case (state_q)
            IDLE: begin
                if (en != 2'b00) begin
                    state_d = FILL;
                    mode_d  = en;
                end
            end
            FILL: begin
                if (flush)
                    state_d = IDLE;
                else if (level >= START_L)
                    state_d = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (pop_req) begin
                    if (mode_q == 2'b11) begin
                        if (empty) begin
                            dunf_d = 1'b1;
                        end else begin
                            consume = 1'b1;
                            dd0_d   = rd_word[63:0];
                            dd1_d   = rd_word[127:64];
                        end
                    end else begin
                        // Single channel: low half, then high half frees the word.
                        if (!phase_q) begin
                            if (empty) begin
                                dunf_d = 1'b1;
                            end else begin
                                half    = rd_word[63:0];
                                phase_d = 1'b1;
                            end
                        end else begin
                            half    = rd_word[127:64];
                            phase_d = 1'b0;
                            consume = 1'b1;
                        end
                        if (mode_q[0])
                            dd0_d = half;
                        else
                            dd1_d = half;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level + (AW+1)'(push) - (AW+1)'(consume);
        if (clr)
            level_d = '0;
        ready_d = (state_d != IDLE) && (level_d != DEPTH_L);
    end

    always_ff @(posedge dac_clk) begin
        if (push)
            mem[wr_ptr] <= s_axis.data;
    end

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state_q      <= IDLE;
            mode_q       <= 2'b00;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            phase_q      <= 1'b0;
            s_axis.ready <= 1'b0;
            dac_ddata_0  <= '0;
            dac_ddata_1  <= '0;
            dac_dunf     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            level        <= level_d;
            s_axis.ready <= ready_d;
            if (clr) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                phase_q     <= 1'b0;
                dac_ddata_0 <= '0;
                dac_ddata_1 <= '0;
                dac_dunf    <= 1'b0;
            end else begin
                wr_ptr      <= wr_ptr + AW'(push);
                rd_ptr      <= rd_ptr + AW'(consume);
                phase_q     <= phase_d;
                dac_ddata_0 <= dd0_d;
                dac_ddata_1 <= dd1_d;
                dac_dunf    <= dunf_d;
            end
        end
    end
endmodule

// File: doc/axi_ad9152_dac_fifo.md
# axi_ad9152_dac_fifo

DMA-side sample buffer that sits directly upstream of the AD9152 DAC core. It accepts 128-bit packed sample words from the TX DMA over a valid/ready stream, buffers them, and answers the core's per-channel `dac_valid`/`dac_enable` requests with 64-bit `dac_ddata` words. When the core requests data that is not there, it raises `dac_dunf`. It also handles prefill before streaming starts, single-channel unpacking, and flush when the channels are disabled.

## Interface
- FIFO_ADDR_WIDTH, 5: log2 of FIFO depth in 128-bit words (depth 32).
- START_LEVEL, 4: FIFO occupancy, in words, at which FILL hands over to RUN; legal range 1..depth.
- dac_clk  in  1  single clock for the whole block (the DAC core clock).
- dac_rstn  in  1  asynchronous active-low reset.
- s_axis_valid  in  1  DMA word valid.
- s_axis_ready  out  1  block can accept a word.
- s_axis_data  in  128  [63:0] ch0 samples, [127:64] ch1 samples (both-enabled mode); two consecutive 64-bit words of the enabled channel, low half first (single-channel mode).
- dac_valid_0, dac_valid_1  in  1 each  core data requests; a pop request = dac_valid_0 | dac_valid_1.
- dac_enable_0, dac_enable_1  in  1 each  channel enables from the core.
- dac_ddata_0, dac_ddata_1  out  64 each  registered sample data to the core.
- dac_dunf  out  1  registered underflow flag, one cycle per failed pop.

## Operation
- Storage: dual-port RAM of 2^FIFO_ADDR_WIDTH x 128, write/read pointers FIFO_ADDR_WIDTH bits wrapping modulo depth, level counter FIFO_ADDR_WIDTH+1 bits; full = (level == depth), empty = (level == 0).
- Mode latched on leaving IDLE: BOTH (en = 2'b11), CH0 (2'b01), CH1 (2'b10).
- FSM states: IDLE, FILL, RUN.
  - IDLE: FIFO flushed (pointers, level, phase = 0); s_axis_ready = 0; outputs 0. Moves to FILL when {en1,en0} != 0.
  - FILL: s_axis_ready = !full; pops return zeros, dunf = 0, nothing is read from the FIFO. Moves to RUN when level >= START_LEVEL.
  - RUN: s_axis_ready = !full; pops consume data as described below.
  - From FILL or RUN: any change of {en1,en0} relative to the latched mode returns the FSM to IDLE (flush). Re-entry to FILL happens next cycle if the new enables are non-zero.
- Pop in RUN, BOTH mode: read one word; ddata_0 = word[63:0], ddata_1 = word[127:64].
- Pop in RUN, single mode: phase bit selects the half. Phase 0 presents word[63:0] to the enabled channel. Phase 1 presents word[127:64] and frees the word. The disabled channel's ddata = 0.
- Underflow: a RUN pop with empty FIFO (phase 0, or BOTH mode) gives ddata = 0 and dunf = 1. Pointers and phase are unchanged and the FSM stays in RUN.
- Simultaneous push and pop: the level is unchanged. There is no write-to-read bypass: a pop on an empty FIFO underflows even if a push occurs in the same cycle.
- Push occurs when s_axis_valid & s_axis_ready. Data offered while ready = 0 is held by the DMA, never dropped.

## Timing
- Reset (async assert, sync release): state = IDLE; s_axis_ready = 0; dac_ddata_0/1 = 0; dac_dunf = 0; pointers, level and phase = 0.
- Read latency: ddata and dunf are valid one dac_clk after the pop cycle; a continuous one pop per cycle is sustained.
- s_axis_ready is registered from the level. It deasserts in the cycle after a push makes the FIFO full, and never permits a write when full.
- The level updates one cycle after a push or pop. The FILL→RUN transition occurs on the first cycle the registered level is >= START_LEVEL.
- Enable change to IDLE takes one cycle. The flush takes effect in that cycle, and outputs are 0 from the following cycle.
- Without pops, the FIFO reaches full after depth accepted words. With ready held high and pops once per cycle in BOTH mode, occupancy stays constant.

## Test plan
- Reset mid-stream: assert dac_rstn low while RUN with 10 words stored -> ready = 0, ddata = 0, dunf = 0 immediately; after release, state IDLE, level 0.
- BOTH mode, START_LEVEL = 4: enable 2'b11, push words W0..W7 (W = {ch1=0x1000+i, ch0=0x2000+i}), pop every cycle -> zeros during FILL; after level hits 4, ddata_0 = 0x2000, 0x2001, ... in order, 1-cycle latency, no dunf.
- CH0 mode: enable 2'b01, push {0xB,0xA},{0xD,0xC} -> ddata_0 sequence 0xA, 0xB, 0xC, 0xD; ddata_1 = 0; two pops per word.
- Underflow: in RUN, stop pushes, pop 6 times with 4 words stored -> 4 valid words, then dunf = 1 on 2 consecutive outputs with ddata = 0; resume pushes -> data continues without dunf and without re-FILL.
- Full/backpressure: depth 32, no pops, s_axis_valid held high -> exactly 32 words accepted, ready = 0 afterwards; one pop -> ready returns 1 cycle later, exactly one more word accepted.
- Enable change: switch 2'b11 -> 2'b01 in RUN -> one IDLE cycle, FIFO flushed, FILL re-entered, no stale BOTH data appears on ddata_0.
